imm_encoder: RTL



---
 rtl/imm_pkg.sv | 11 +
 rtl/imm_encoder_rotate_left.sv | 18 +
 rtl/imm_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types and field widths for the rotated-immediate encoder.
package imm_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} imm_state_t;

  localparam int IMM_BITS  = 8;
  localparam int ROT_BITS  = 4;
  localparam int ROT_STEPS = 16;
  localparam int WORD_BITS = 32;

endpackage

// File: rtl/imm_encoder_rotate_left.sv
// Combinational rotate-left; shared with the extender's rotate path.
module rotate_left #(
  parameter int num_bits = 32
) (
  input  logic [num_bits-1:0] a,
  input  logic [4:0]          shamt,
  output logic [num_bits-1:0] y
);

  logic [2*num_bits-1:0] dbl;

  // Upper half of the shifted doubled word is the rotated value.
  always_comb begin
    dbl = {a, a} << shamt;
    y   = dbl[2*num_bits-1:num_bits];
  end

endmodule

// File: rtl/imm_encoder.sv
// Searches, one rotation per cycle, for the smallest rot such that
// ROR(imm8, 2*rot) reproduces the latched 32-bit value.
module imm_encoder
  import imm_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [WORD_BITS-1:0]          value,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic [IMM_BITS-1:0]           imm8,
  output logic [ROT_BITS-1:0]           rot,
  output logic [ROT_BITS+IMM_BITS-1:0]  operand2
);

  imm_state_t           state_q, state_d;
  logic [WORD_BITS-1:0] value_q, value_d;
  logic [ROT_BITS-1:0]  r_q, r_d;
  logic [IMM_BITS-1:0]  imm8_q, imm8_d;
  logic [ROT_BITS-1:0]  rot_q, rot_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WORD_BITS-1:0] cand;
  logic                 hit;

  rotate_left #(.num_bits(WORD_BITS)) u_rol (
    .a     (value_q),
    .shamt ({r_q, 1'b0}),
    .y     (cand)
  );

  assign hit = (cand[WORD_BITS-1:IMM_BITS] == '0);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    r_d     = r_q;
    imm8_d  = imm8_q;
    rot_d   = rot_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          value_d = value;
          r_d     = '0;
          valid_d = 1'b0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          imm8_d  = cand[IMM_BITS-1:0];
          rot_d   = r_q;
          valid_d = 1'b1;
          state_d = DONE;
        end else if (r_q == ROT_BITS'(ROT_STEPS - 1)) begin
          imm8_d  = '0;
          rot_d   = '0;
          valid_d = 1'b0;
          state_d = DONE;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      value_q <= '0;
      r_q     <= '0;
      imm8_q  <= '0;
      rot_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      r_q     <= r_d;
      imm8_q  <= imm8_d;
      rot_q   <= rot_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign valid    = valid_q;
  assign imm8     = imm8_q;
  assign rot      = rot_q;
  assign operand2 = {rot_q, imm8_q};

endmodule
